mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/mem_port_arbiter_tag_pipe.sv | 37 +++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: requester tag encoding and default widths.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF     = 18;
  localparam int DATA_W_DEF     = 8;
  localparam int RD_LAT_DEF     = 2;
  localparam int STARVE_MAX_DEF = 8;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGA  = 2'd1,
    TAG_HOST = 2'd2,
    TAG_ALG  = 2'd3
  } tag_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter; slave = arbiter, master = requesters plus memory.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;

  logic              alg_req;
  logic              alg_we;
  logic [ADDR_W-1:0] alg_addr;
  logic [DATA_W-1:0] alg_wdata;
  logic              alg_gnt;

  logic [DATA_W-1:0] rdata;
  logic              vga_rvalid;
  logic              host_rvalid;
  logic              alg_rvalid;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  vga_req, vga_addr,
    input  host_req, host_we, host_addr, host_wdata,
    input  alg_req, alg_we, alg_addr, alg_wdata,
    input  mem_q,
    output vga_gnt, host_gnt, alg_gnt,
    output rdata, vga_rvalid, host_rvalid, alg_rvalid,
    output mem_addr, mem_data, mem_wren
  );

  modport master (
    output vga_req, vga_addr,
    output host_req, host_we, host_addr, host_wdata,
    output alg_req, alg_we, alg_addr, alg_wdata,
    output mem_q,
    input  vga_gnt, host_gnt, alg_gnt,
    input  rdata, vga_rvalid, host_rvalid, alg_rvalid,
    input  mem_addr, mem_data, mem_wren
  );

endinterface

// File: rtl/mem_port_arbiter_tag_pipe.sv
// Read-owner tag shift pipeline; the last stage lines up with mem_q and steers it to the owning requester.
module arb_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  tag_e              tag_i,
  input  logic [DATA_W-1:0] mem_q_i,
  output logic              vga_rvalid_o,
  output logic              host_rvalid_o,
  output logic              alg_rvalid_o,
  output logic [DATA_W-1:0] rdata_o
);

  // Stage 0 tracks the cycle mem_addr is on the bus; stage RD_LAT tracks the cycle mem_q is valid.
  tag_e tag_q [RD_LAT+1];
  tag_e tag_out;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= RD_LAT; k++) tag_q[k] <= TAG_NONE;
    end else begin
      tag_q[0] <= tag_i;
      for (int k = 1; k <= RD_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign tag_out       = tag_q[RD_LAT];
  assign vga_rvalid_o  = (tag_out == TAG_VGA);
  assign host_rvalid_o = (tag_out == TAG_HOST);
  assign alg_rvalid_o  = (tag_out == TAG_ALG);
  assign rdata_o       = (tag_out != TAG_NONE) ? mem_q_i : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-way single-port image memory arbiter (VGA > host > alg) with registered memory command.
// Optional alg starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic               clock,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("RD_LAT must be in 1..4");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("STARVE_MAX must fit the 4-bit starvation counter");
  end

  logic              vga_gnt;
  logic              host_gnt;
  logic              alg_gnt;
  logic              alg_force;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_wren_q, mem_wren_d;
  tag_e              rd_tag_d;

  logic              vga_rvalid;
  logic              host_rvalid;
  logic              alg_rvalid;
  logic [DATA_W-1:0] rdata;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (alg_gnt)
      starve_d = '0;
    else if (bus.alg_req && starve_q != 4'hF)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) starve_q <= '0;
    else          starve_q <= starve_d;
  end

  assign alg_force = (starve_q >= STARVE_LIM);
`else
  assign alg_force = 1'b0;
`endif

  // Grants are combinational from req and registered state, and held low while in reset.
  always_comb begin
    vga_gnt  = 1'b0;
    host_gnt = 1'b0;
    alg_gnt  = 1'b0;
    if (reset_n) begin
      if (alg_force && bus.alg_req) alg_gnt  = 1'b1;
      else if (bus.vga_req)         vga_gnt  = 1'b1;
      else if (bus.host_req)        host_gnt = 1'b1;
      else if (bus.alg_req)         alg_gnt  = 1'b1;
    end
  end

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_wren_d = 1'b0;
    rd_tag_d   = TAG_NONE;
    if (vga_gnt) begin
      mem_addr_d = bus.vga_addr;
      rd_tag_d   = TAG_VGA;
    end else if (host_gnt) begin
      mem_addr_d = bus.host_addr;
      mem_data_d = bus.host_wdata;
      mem_wren_d = bus.host_we;
      rd_tag_d   = bus.host_we ? TAG_NONE : TAG_HOST;
    end else if (alg_gnt) begin
      mem_addr_d = bus.alg_addr;
      mem_data_d = bus.alg_wdata;
      mem_wren_d = bus.alg_we;
      rd_tag_d   = bus.alg_we ? TAG_NONE : TAG_ALG;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wren_q <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wren_q <= mem_wren_d;
    end
  end

  arb_tag_pipe #(
    .RD_LAT (RD_LAT),
    .DATA_W (DATA_W)
  ) u_tag_pipe (
    .clock         (clock),
    .reset_n       (reset_n),
    .tag_i         (rd_tag_d),
    .mem_q_i       (bus.mem_q),
    .vga_rvalid_o  (vga_rvalid),
    .host_rvalid_o (host_rvalid),
    .alg_rvalid_o  (alg_rvalid),
    .rdata_o       (rdata)
  );

  assign bus.vga_gnt     = vga_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.alg_gnt     = alg_gnt;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_wren    = mem_wren_q;
  assign bus.vga_rvalid  = vga_rvalid;
  assign bus.host_rvalid = host_rvalid;
  assign bus.alg_rvalid  = alg_rvalid;
  assign bus.rdata       = rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural RD_LAT memory and a queue-based scoreboard.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 18;
  localparam int DW = 8;
  localparam int RL = 2;
  localparam int SM = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic preload = 1'b1;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .RD_LAT     (RL),
    .STARVE_MAX (SM)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory: write on mem_wren, read data appears RL cycles after mem_addr is presented.
  logic [DW-1:0] mem    [0:255];
  logic [DW-1:0] pipe_q [0:3];
  always @(posedge clock) begin
    if (preload) begin
      mem[8'h10] <= 8'h5A;
      mem[8'h30] <= 8'hEE;
      mem[8'h40] <= 8'h11;
      mem[8'h41] <= 8'h22;
      mem[8'h42] <= 8'h33;
    end else if (bus.mem_wren) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_data;
    end
    pipe_q[0] <= mem[bus.mem_addr[7:0]];
    for (int k = 1; k < 4; k++) pipe_q[k] <= pipe_q[k-1];
  end
  assign bus.mem_q = pipe_q[RL-1];

  typedef struct {
    int          due;
    logic        we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct {
    int          due;
    tag_e        owner;
    logic [DW-1:0] data;
  } rd_t;

  op_t opq[$];
  rd_t rdq[$];

  logic [DW-1:0] vga_exp, host_exp, alg_exp;

  task automatic monitor();
    logic [40:0]   obs;
    logic [2:0]    exp_rv;
    logic [2:0]    obs_rv;
    logic [DW-1:0] exp_rd;
    if (!reset_n) begin
      obs = {bus.vga_gnt, bus.host_gnt, bus.alg_gnt,
             bus.vga_rvalid, bus.host_rvalid, bus.alg_rvalid,
             bus.mem_wren, bus.mem_addr, bus.mem_data, bus.rdata};
      checks++;
      assert (obs === 41'd0) else begin
        errors++;
        $error("FAIL reset_outputs cyc=%0d observed=%h expected=0", cyc, obs);
      end
    end else begin
      exp_rv = 3'b000;
      exp_rd = '0;
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        case (rdq[0].owner)
          TAG_VGA:  exp_rv = 3'b100;
          TAG_HOST: exp_rv = 3'b010;
          TAG_ALG:  exp_rv = 3'b001;
          default:  exp_rv = 3'b000;
        endcase
        exp_rd = rdq[0].data;
        void'(rdq.pop_front());
      end
      obs_rv = {bus.vga_rvalid, bus.host_rvalid, bus.alg_rvalid};
      checks++;
      assert ({obs_rv, bus.rdata} === {exp_rv, exp_rd}) else begin
        errors++;
        $error("FAIL rvalid_rdata cyc=%0d observed=%b/%h expected=%b/%h",
               cyc, obs_rv, bus.rdata, exp_rv, exp_rd);
      end
      if (opq.size() > 0 && opq[0].due == cyc) begin
        checks++;
        assert (bus.mem_wren === opq[0].we && bus.mem_addr === opq[0].addr &&
                (!opq[0].we || bus.mem_data === opq[0].data)) else begin
          errors++;
          $error("FAIL mem_cmd cyc=%0d observed=%b/%h/%h expected=%b/%h/%h", cyc,
                 bus.mem_wren, bus.mem_addr, bus.mem_data, opq[0].we, opq[0].addr, opq[0].data);
        end
        void'(opq.pop_front());
      end else begin
        checks++;
        assert (bus.mem_wren === 1'b0) else begin
          errors++;
          $error("FAIL mem_wren_idle cyc=%0d observed=%b expected=0", cyc, bus.mem_wren);
        end
      end
    end
  endtask

  // One clock cycle: check grants, book accepted transfers, run the output monitor, drop granted requests.
  task automatic tick(input logic [2:0] exp_gnt);
    logic [2:0] got;
    #1;
    got = {bus.vga_gnt, bus.host_gnt, bus.alg_gnt};
    checks++;
    assert (got === exp_gnt) else begin
      errors++;
      $error("FAIL grant cyc=%0d observed=%b expected=%b", cyc, got, exp_gnt);
    end
    if (exp_gnt[2]) begin
      opq.push_back(op_t'{cyc + 1, 1'b0, bus.vga_addr, 8'h00});
      rdq.push_back(rd_t'{cyc + 1 + RL, TAG_VGA, vga_exp});
    end
    if (exp_gnt[1]) begin
      opq.push_back(op_t'{cyc + 1, bus.host_we, bus.host_addr, bus.host_wdata});
      if (!bus.host_we) rdq.push_back(rd_t'{cyc + 1 + RL, TAG_HOST, host_exp});
    end
    if (exp_gnt[0]) begin
      opq.push_back(op_t'{cyc + 1, bus.alg_we, bus.alg_addr, bus.alg_wdata});
      if (!bus.alg_we) rdq.push_back(rd_t'{cyc + 1 + RL, TAG_ALG, alg_exp});
    end
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
    if (exp_gnt[2]) bus.vga_req  = 1'b0;
    if (exp_gnt[1]) bus.host_req = 1'b0;
    if (exp_gnt[0]) bus.alg_req  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(3'b000);
  endtask

  task automatic set_vga(input logic [AW-1:0] a, input logic [DW-1:0] e);
    bus.vga_req  = 1'b1;
    bus.vga_addr = a;
    vga_exp      = e;
  endtask

  task automatic set_host(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] e);
    bus.host_req   = 1'b1;
    bus.host_we    = w;
    bus.host_addr  = a;
    bus.host_wdata = d;
    host_exp       = e;
  endtask

  task automatic set_alg(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] e);
    bus.alg_req   = 1'b1;
    bus.alg_we    = w;
    bus.alg_addr  = a;
    bus.alg_wdata = d;
    alg_exp       = e;
  endtask

  task automatic all_reqs(input logic v);
    bus.vga_req    = v;
    bus.host_req   = v;
    bus.alg_req    = v;
    bus.host_we    = v;
    bus.alg_we     = v;
    bus.vga_addr   = v ? '1 : '0;
    bus.host_addr  = v ? '1 : '0;
    bus.alg_addr   = v ? '1 : '0;
    bus.host_wdata = v ? '1 : '0;
    bus.alg_wdata  = v ? '1 : '0;
  endtask

  initial begin
    vga_exp  = '0;
    host_exp = '0;
    alg_exp  = '0;
    all_reqs(1'b1);

    // Power-on reset with every request asserted: all outputs must stay zero.
    repeat (3) tick(3'b000);
    preload = 1'b0;
    all_reqs(1'b0);
    reset_n = 1'b1;
    idle(2);

    // Single VGA read.
    set_vga(18'h00010, 8'h5A);
    tick(3'b100);
    idle(4);

    // VGA read and host write together: VGA first, host next cycle.
    set_vga(18'h00010, 8'h5A);
    set_host(1'b1, 18'h00020, 8'hC3, 8'h00);
    tick(3'b100);
    tick(3'b010);
    idle(4);

    // Host write then host read of the same address on consecutive cycles.
    set_host(1'b1, 18'h00030, 8'h77, 8'h00);
    tick(3'b010);
    set_host(1'b0, 18'h00030, 8'h00, 8'h77);
    tick(3'b010);
    idle(4);

    // Three-way contention, then alg reads back its own write.
    set_vga(18'h00040, 8'h11);
    set_host(1'b0, 18'h00042, 8'h00, 8'h33);
    set_alg(1'b1, 18'h00021, 8'h44, 8'h00);
    tick(3'b100);
    tick(3'b010);
    tick(3'b001);
    set_alg(1'b0, 18'h00021, 8'h00, 8'h44);
    tick(3'b001);
    idle(4);

    // Interleaved reads vga/alg/host back to back.
    set_vga(18'h00040, 8'h11);
    tick(3'b100);
    set_alg(1'b0, 18'h00041, 8'h00, 8'h22);
    tick(3'b001);
    set_host(1'b0, 18'h00042, 8'h00, 8'h33);
    tick(3'b010);
    set_vga(18'h00020, 8'hC3);
    tick(3'b100);
    idle(5);

    // alg competing against a continuous VGA stream.
`ifdef ARB_STARVE_GUARD_EN
    for (int r = 0; r < 2; r++) begin
      set_alg(1'b0, 18'h00041, 8'h00, 8'h22);
      for (int i = 0; i < SM; i++) begin
        set_vga(18'h00010, 8'h5A);
        tick(3'b100);
      end
      set_vga(18'h00010, 8'h5A);
      tick(3'b001);
    end
    bus.vga_req = 1'b0;
`else
    set_alg(1'b0, 18'h00041, 8'h00, 8'h22);
    for (int i = 0; i < 20; i++) begin
      set_vga(18'h00010, 8'h5A);
      tick(3'b100);
    end
    bus.vga_req = 1'b0;
    tick(3'b001);
`endif
    idle(5);

    // Reset with two reads in flight: both must be discarded.
    set_vga(18'h00010, 8'h5A);
    tick(3'b100);
    set_host(1'b0, 18'h00030, 8'h00, 8'h77);
    tick(3'b010);
    reset_n = 1'b0;
    opq.delete();
    rdq.delete();
    all_reqs(1'b1);
    tick(3'b000);
    tick(3'b000);
    all_reqs(1'b0);
    reset_n = 1'b1;
    idle(6);

    // First read after reset returns normally.
    set_vga(18'h00042, 8'h33);
    tick(3'b100);

    for (int i = 0; i < 10 && (opq.size() > 0 || rdq.size() > 0); i++) tick(3'b000);
    checks++;
    assert (opq.size() == 0 && rdq.size() == 0) else begin
      errors++;
      $error("FAIL drain observed=%0d/%0d pending expected=0/0", opq.size(), rdq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
